// File: rtl/ex_iter_alu_pkg.sv
// Shared definitions for the execute stage: ALU sub-operation codes,
// result-class selectors, divider FSM encodings and a small decode helper.
package ex_iter_alu_pkg;

  // aluop codes (sub-operation from ID/EX)
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // alusel codes (result class)
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // True for either divide flavour; both only write HI/LO.
  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_iter_alu_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// master: pipeline side (drives operands/controls, receives results).
// slave : the execute stage itself.
interface ex_iter_alu_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic [7:0]       aluop;
  logic [2:0]       alusel;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic [RADDR-1:0] w_addr_i;
  logic             we_i;
  logic             flush;
  logic             we_o;
  logic [RADDR-1:0] w_addr_o;
  logic [WIDTH-1:0] w_data_o;
  logic             hi_we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             stall_req_o;

  modport master (
    output aluop, alusel, reg1, reg2, w_addr_i, we_i, flush,
    input  we_o, w_addr_o, w_data_o, hi_we_o, hi_o, lo_o, stall_req_o
  );

  modport slave (
    input  aluop, alusel, reg1, reg2, w_addr_i, we_i, flush,
    output we_o, w_addr_o, w_data_o, hi_we_o, hi_o, lo_o, stall_req_o
  );
endinterface

// File: rtl/ex_iter_alu_div_iter.sv
// Iterative radix-2 restoring divider (one quotient bit per cycle, MSB first).
// Ports: start/flush/signed_op control, dividend/divisor operands (must stay
// stable while busy), busy = stall request, done = one-cycle result strobe,
// q/r = sign-corrected quotient/remainder (valid while done).
module ex_iter_alu_div_iter
  import ex_iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quot_q, quot_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // |divisor|
  logic             neg_q_q, neg_q_d; // negate quotient at the end
  logic             neg_r_q, neg_r_d; // negate remainder at the end

  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_abs_s, b_abs_s;
  logic [WIDTH:0]   shifted_s;
  logic             ge_s;

  // operand magnitudes and the single restoring step
  always_comb begin
    a_neg_s   = signed_op & dividend[WIDTH-1];
    b_neg_s   = signed_op & divisor[WIDTH-1];
    a_abs_s   = a_neg_s ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
    b_abs_s   = b_neg_s ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;
    shifted_s = {rem_q, quot_q[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, dvs_q});
  end

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          count_d = CW'(WIDTH);
          dvs_d   = b_abs_s;
          if (divisor == {WIDTH{1'b0}}) begin
            // divide by zero: fixed result, no iteration, no sign fix-up
            quot_d  = {WIDTH{1'b1}};
            rem_d   = dividend;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = DIV_DONE;
          end else begin
            quot_d  = a_abs_s;
            rem_d   = {WIDTH{1'b0}};
            neg_q_d = a_neg_s ^ b_neg_s;
            neg_r_d = a_neg_s;
            state_d = DIV_BUSY;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d  = ge_s ? (shifted_s[WIDTH-1:0] - dvs_q) : shifted_s[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], ge_s};
          if (count_q == CW'(1)) begin
            state_d = DIV_DONE;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      count_q <= {CW{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  // status and sign-corrected results; MIN/-1 wraps back to MIN naturally
  always_comb begin
    busy = ((state_q == DIV_IDLE) && start && !flush) || (state_q == DIV_BUSY);
    done = (state_q == DIV_DONE) && !flush;
    q    = neg_q_q ? (~quot_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quot_q;
    r    = neg_r_q ? (~rem_q  + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;
  end

endmodule

// File: rtl/ex_iter_alu.sv
// Execute stage: combinational logic/shift/arith ALU plus an iterative
// DIV/DIVU unit that writes HI/LO and stalls the pipeline while running.
// Ports: clk, rst (synchronous, active-high), bus (ex_iter_alu_if.slave):
// operands/controls from ID/EX in, GPR write, HI/LO write and stall out.
module ex_iter_alu
  import ex_iter_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int RADDR = 5
) (
  input logic            clk,
  input logic            rst,
  ex_iter_alu_if.slave   bus
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [WIDTH-1:0] logic_res_s, shift_res_s, arith_res_s, alu_res_s;
  logic [SHW-1:0]   shamt_s;
  logic             div_op_s, div_busy_s, div_done_s;
  logic [WIDTH-1:0] div_q_s, div_r_s;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // per-class results; an unknown aluop inside a class yields zero
  always_comb begin
    shamt_s     = bus.reg1[SHW-1:0];
    logic_res_s = ZERO_W;
    shift_res_s = ZERO_W;
    arith_res_s = ZERO_W;
    case (bus.aluop)
      EXE_OR_OP:  logic_res_s = bus.reg1 | bus.reg2;
      EXE_AND_OP: logic_res_s = bus.reg1 & bus.reg2;
      EXE_XOR_OP: logic_res_s = bus.reg1 ^ bus.reg2;
      EXE_NOR_OP: logic_res_s = ~(bus.reg1 | bus.reg2);
      default:    logic_res_s = ZERO_W;
    endcase
    case (bus.aluop)
      EXE_SLL_OP: shift_res_s = bus.reg2 << shamt_s;
      EXE_SRL_OP: shift_res_s = bus.reg2 >> shamt_s;
      EXE_SRA_OP: shift_res_s = $signed(bus.reg2) >>> shamt_s;
      default:    shift_res_s = ZERO_W;
    endcase
    case (bus.aluop)
      EXE_ADD_OP:  arith_res_s = bus.reg1 + bus.reg2;
      EXE_SUB_OP:  arith_res_s = bus.reg1 - bus.reg2;
      EXE_SLT_OP:  arith_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.reg1) < $signed(bus.reg2))};
      EXE_SLTU_OP: arith_res_s = {{(WIDTH-1){1'b0}}, (bus.reg1 < bus.reg2)};
      default:     arith_res_s = ZERO_W;
    endcase
  end

  // class select; NOP or unknown class gives zero
  always_comb begin
    case (bus.alusel)
      EXE_RES_LOGIC: alu_res_s = logic_res_s;
      EXE_RES_SHIFT: alu_res_s = shift_res_s;
      EXE_RES_ARITH: alu_res_s = arith_res_s;
      default:       alu_res_s = ZERO_W;
    endcase
  end

  assign div_op_s = is_div_op(bus.aluop);

  ex_iter_alu_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_op_s),
    .flush     (bus.flush),
    .signed_op (bus.aluop == EXE_DIV_OP),
    .dividend  (bus.reg1),
    .divisor   (bus.reg2),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .q         (div_q_s),
    .r         (div_r_s)
  );

  // HI/LO hold value: captured on the result strobe so outputs stay put afterwards
  always_comb begin
    if (div_done_s) begin
      hi_d = div_r_s;
      lo_d = div_q_s;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // HI/LO hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= ZERO_W;
      lo_q <= ZERO_W;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // outputs are forced to zero while reset is asserted
  always_comb begin
    if (rst) begin
      bus.we_o        = 1'b0;
      bus.w_addr_o    = {RADDR{1'b0}};
      bus.w_data_o    = ZERO_W;
      bus.hi_we_o     = 1'b0;
      bus.hi_o        = ZERO_W;
      bus.lo_o        = ZERO_W;
      bus.stall_req_o = 1'b0;
    end else begin
      bus.we_o        = bus.we_i & ~div_op_s;
      bus.w_addr_o    = bus.w_addr_i;
      bus.w_data_o    = alu_res_s;
      bus.hi_we_o     = div_done_s;
      bus.hi_o        = hi_d;
      bus.lo_o        = lo_d;
      bus.stall_req_o = div_busy_s;
    end
  end

endmodule
